// File: rtl/mips_mc_ctrl_if.sv
// Shared memory-port handshake between the multi-cycle controller and memory.
// Handshake: the controller holds mem_req (with mem_we qualifying the access
// type) high until a cycle in which memory returns mem_ready=1; the access
// completes in that cycle. mem_we is meaningful only while mem_req is high.
interface mips_mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a
// shared datapath and one memory port, drives all datapath enables and mux
// selects, halts on HLT or an unsupported instruction, and counts retired
// instructions.
module mips_mc_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    mips_mc_ctrl_if.master       mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           npc_sel,
    output logic                 reg_write_en,
    output logic [1:0]           reg_dst,
    output logic [1:0]           wd_sel,
    output logic [2:0]           alu_op,
    output logic                 alu_src_imm,
    output logic                 ext_sign,
    output logic                 halt_sig,
    output logic                 illegal,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'b00_0000;
    localparam logic [5:0] OP_J       = 6'b00_0010;
    localparam logic [5:0] OP_JAL     = 6'b00_0011;
    localparam logic [5:0] OP_BEQ     = 6'b00_0100;
    localparam logic [5:0] OP_ADDI    = 6'b00_1000;
    localparam logic [5:0] OP_ADDIU   = 6'b00_1001;
    localparam logic [5:0] OP_ORI     = 6'b00_1101;
    localparam logic [5:0] OP_LUI     = 6'b00_1111;
    localparam logic [5:0] OP_LW      = 6'b10_0011;
    localparam logic [5:0] OP_SW      = 6'b10_1011;
    localparam logic [5:0] OP_HLT     = 6'b11_1111;

    localparam logic [5:0] FN_ADDU = 6'b10_0001;
    localparam logic [5:0] FN_SUBU = 6'b10_0011;
    localparam logic [5:0] FN_SLT  = 6'b10_1010;
    localparam logic [5:0] FN_JR   = 6'b00_1000;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;
    localparam logic [2:0] ALU_LUI = 3'd4;

    state_t state_q;
    state_t state_d;
    logic   illegal_q;
    logic   retire;
    logic   set_illegal;

    logic is_special, is_addu, is_subu, is_slt, is_jr, is_r_alu;
    logic is_j, is_jal, is_beq, is_addi, is_ori, is_lui, is_lw, is_sw, is_hlt;
    logic is_legal;

    // Instruction classification from the (stable) IR fields.
    always_comb begin
        is_special = (opcode == OP_SPECIAL);
        is_addu    = is_special && (funct == FN_ADDU);
        is_subu    = is_special && (funct == FN_SUBU);
        is_slt     = is_special && (funct == FN_SLT);
        is_jr      = is_special && (funct == FN_JR);
        is_r_alu   = is_addu || is_subu || is_slt;
        is_j       = (opcode == OP_J);
        is_jal     = (opcode == OP_JAL);
        is_beq     = (opcode == OP_BEQ);
        // ADDI behaves exactly like ADDIU: no overflow trap.
        is_addi    = (opcode == OP_ADDI) || (opcode == OP_ADDIU);
        is_ori     = (opcode == OP_ORI);
        is_lui     = (opcode == OP_LUI);
        is_lw      = (opcode == OP_LW);
        is_sw      = (opcode == OP_SW);
        is_hlt     = (opcode == OP_HLT);
        is_legal   = is_r_alu || is_jr || is_j || is_jal || is_beq || is_addi ||
                     is_ori || is_lui || is_lw || is_sw;
    end

    // Next-state and strobe decode; reset forces every strobe low.
    always_comb begin
        state_d      = state_q;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        npc_sel      = 2'd0;
        reg_write_en = 1'b0;
        reg_dst      = 2'd0;
        wd_sel       = 2'd0;
        alu_op       = ALU_ADD;
        alu_src_imm  = 1'b0;
        ext_sign     = 1'b0;
        retire       = 1'b0;
        set_illegal  = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    npc_sel  = 2'd0;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_hlt) begin
                    state_d = S_HALT;
                end else if (!is_legal) begin
                    state_d     = S_HALT;
                    set_illegal = 1'b1;
                end else if (is_j) begin
                    pc_write = 1'b1;
                    npc_sel  = 2'd2;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_jal) begin
                    pc_write     = 1'b1;
                    npc_sel      = 2'd2;
                    reg_write_en = 1'b1;
                    reg_dst      = 2'd2;
                    wd_sel       = 2'd2;
                    retire       = 1'b1;
                    state_d      = S_FETCH;
                end else if (is_jr) begin
                    pc_write = 1'b1;
                    npc_sel  = 2'd3;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    pc_write = zero;
                    npc_sel  = 2'd1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = is_sw;
                if (mem.mem_ready) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write_en = 1'b1;
                reg_dst      = is_r_alu ? 2'd1 : 2'd0;
                wd_sel       = is_lw ? 2'd1 : 2'd0;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // ALU controls are held from EXEC through MEM and WB.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            if (is_r_alu) begin
                alu_op      = is_subu ? ALU_SUB : (is_slt ? ALU_SLT : ALU_ADD);
                alu_src_imm = 1'b0;
            end else if (is_beq) begin
                alu_op      = ALU_SUB;
                alu_src_imm = 1'b0;
            end else if (is_ori) begin
                alu_op      = ALU_OR;
                alu_src_imm = 1'b1;
                ext_sign    = 1'b0;
            end else if (is_lui) begin
                alu_op      = ALU_LUI;
                alu_src_imm = 1'b1;
            end else if (is_addi || is_lw || is_sw) begin
                alu_op      = ALU_ADD;
                alu_src_imm = 1'b1;
                ext_sign    = 1'b1;
            end
        end

        // A reset cycle abandons the current instruction with no side effects.
        if (reset) begin
            state_d      = S_FETCH;
            mem.mem_req  = 1'b0;
            mem.mem_we   = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            reg_write_en = 1'b0;
            retire       = 1'b0;
            set_illegal  = 1'b0;
        end
    end

    // State register, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret   <= '0;
        end else begin
            state_q <= state_d;
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign state    = state_q;
    assign halt_sig = (state_q == S_HALT);
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed testbench for the multi-cycle MIPS control FSM.
module tb_mips_mc_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        ir_write, pc_write, reg_write_en, alu_src_imm, ext_sign;
    logic        halt_sig, illegal;
    logic [1:0]  npc_sel, reg_dst, wd_sel;
    logic [2:0]  alu_op, state;
    logic [31:0] instret;

    mips_mc_ctrl_if mem_bus ();

    mips_mc_ctrl #(.INSTRET_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .mem          (mem_bus.master),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .npc_sel      (npc_sel),
        .reg_write_en (reg_write_en),
        .reg_dst      (reg_dst),
        .wd_sel       (wd_sel),
        .alu_op       (alu_op),
        .alu_src_imm  (alu_src_imm),
        .ext_sign     (ext_sign),
        .halt_sig     (halt_sig),
        .illegal      (illegal),
        .state        (state),
        .instret      (instret)
    );

    int          tests_run = 0;
    int          failures  = 0;
    logic [31:0] exp_instret;

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance exactly one rising edge and land just after the falling edge.
    task automatic next_cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        opcode = 6'd0;
        funct = 6'd0;
        zero = 1'b0;
        mem_bus.mem_ready = 1'b1;
        next_cyc();
        reset = 1'b0;
        exp_instret = 32'd0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        opcode = 6'd0;
        funct = 6'd0;
        zero = 1'b0;
        mem_bus.mem_ready = 1'b1;
        #1;
        tests_run++;
        if ({mem_bus.mem_req, mem_bus.mem_we, ir_write, pc_write, reg_write_en} !== 5'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {mem_bus.mem_req, mem_bus.mem_we, ir_write, pc_write, reg_write_en});
        end
        next_cyc();
        reset = 1'b0;
        exp_instret = 32'd0;
        #1;
        tests_run++;
        if ({state, halt_sig, illegal, mem_bus.mem_req} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got state=%0d halt=%b ill=%b req=%b expected 0 0 0 1",
                     state, halt_sig, illegal, mem_bus.mem_req);
        end
        tests_run++;
        if (instret !== 32'd0) begin
            failures++;
            $display("FAIL reset_instret: got %0d expected 0", instret);
        end
    endtask

    task automatic test_addu();
        logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        opcode = 6'b00_0000;
        funct = 6'b10_0001;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({state, reg_write_en} !== {exp_st[i], (i == 3)}) begin
                failures++;
                $display("FAIL addu_cyc%0d: got state=%0d rwe=%b expected %0d %b",
                         i, state, reg_write_en, exp_st[i], (i == 3));
            end
            if (i == 0) begin
                tests_run++;
                if ({mem_bus.mem_req, ir_write, pc_write, npc_sel} !== {3'b111, 2'd0}) begin
                    failures++;
                    $display("FAIL addu_fetch: got %b expected 11100",
                             {mem_bus.mem_req, ir_write, pc_write, npc_sel});
                end
            end
            if (i == 3) begin
                tests_run++;
                if ({reg_dst, wd_sel, alu_op, alu_src_imm} !== {2'd1, 2'd0, 3'd0, 1'b0}) begin
                    failures++;
                    $display("FAIL addu_wb: got dst=%0d wd=%0d op=%0d imm=%b expected 1 0 0 0",
                             reg_dst, wd_sel, alu_op, alu_src_imm);
                end
            end
            next_cyc();
        end
        exp_instret = exp_instret + 32'd1;
        tests_run++;
        if ({state, instret} !== {3'd0, exp_instret}) begin
            failures++;
            $display("FAIL addu_retire: got state=%0d instret=%0d expected 0 %0d",
                     state, instret, exp_instret);
        end
    endtask

    task automatic test_lw_wait();
        logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        logic       rdy    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 6'b10_0011;
        funct = 6'd0;
        for (int i = 0; i < 8; i++) begin
            mem_bus.mem_ready = rdy[i];
            #1;
            tests_run++;
            if (state !== exp_st[i]) begin
                failures++;
                $display("FAIL lw_state_cyc%0d: got %0d expected %0d", i, state, exp_st[i]);
            end
            if (exp_st[i] == 3'd3) begin
                tests_run++;
                if ({mem_bus.mem_req, mem_bus.mem_we, alu_op, alu_src_imm, ext_sign} !==
                    {1'b1, 1'b0, 3'd0, 1'b1, 1'b1}) begin
                    failures++;
                    $display("FAIL lw_mem_cyc%0d: got req=%b we=%b op=%0d imm=%b sx=%b expected 1 0 0 1 1",
                             i, mem_bus.mem_req, mem_bus.mem_we, alu_op, alu_src_imm, ext_sign);
                end
            end
            if (exp_st[i] == 3'd4) begin
                tests_run++;
                if ({reg_write_en, reg_dst, wd_sel} !== {1'b1, 2'd0, 2'd1}) begin
                    failures++;
                    $display("FAIL lw_wb: got rwe=%b dst=%0d wd=%0d expected 1 0 1",
                             reg_write_en, reg_dst, wd_sel);
                end
            end
            next_cyc();
        end
        mem_bus.mem_ready = 1'b1;
        exp_instret = exp_instret + 32'd1;
        tests_run++;
        if ({state, instret} !== {3'd0, exp_instret}) begin
            failures++;
            $display("FAIL lw_retire: got state=%0d instret=%0d expected 0 %0d",
                     state, instret, exp_instret);
        end
    endtask

    task automatic test_beq(input logic z);
        opcode = 6'b00_0100;
        funct = 6'd0;
        zero = z;
        next_cyc();
        next_cyc();
        tests_run++;
        if ({state, pc_write, npc_sel, alu_op, alu_src_imm} !== {3'd2, z, 2'd1, 3'd1, 1'b0}) begin
            failures++;
            $display("FAIL beq_exec_z%0b: got state=%0d pcw=%b npc=%0d op=%0d imm=%b expected 2 %b 1 1 0",
                     z, state, pc_write, npc_sel, alu_op, alu_src_imm, z);
        end
        next_cyc();
        exp_instret = exp_instret + 32'd1;
        tests_run++;
        if ({state, instret} !== {3'd0, exp_instret}) begin
            failures++;
            $display("FAIL beq_retire_z%0b: got state=%0d instret=%0d expected 0 %0d",
                     z, state, instret, exp_instret);
        end
        zero = 1'b0;
    endtask

    // J / JAL / JR all complete in DECODE.
    task automatic test_jumps();
        logic [5:0] ops [3] = '{6'b00_0011, 6'b00_0010, 6'b00_0000};
        logic [1:0] nsel[3] = '{2'd2, 2'd2, 2'd3};
        logic       link[3] = '{1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            funct = 6'b00_1000;
            next_cyc();
            tests_run++;
            if ({state, pc_write, npc_sel} !== {3'd1, 1'b1, nsel[k]}) begin
                failures++;
                $display("FAIL jump%0d_decode: got state=%0d pcw=%b npc=%0d expected 1 1 %0d",
                         k, state, pc_write, npc_sel, nsel[k]);
            end
            tests_run++;
            if ({reg_write_en, reg_dst, wd_sel} !== (link[k] ? {1'b1, 2'd2, 2'd2} : 5'b0)) begin
                failures++;
                $display("FAIL jump%0d_link: got rwe=%b dst=%0d wd=%0d link=%b",
                         k, reg_write_en, reg_dst, wd_sel, link[k]);
            end
            next_cyc();
            exp_instret = exp_instret + 32'd1;
            tests_run++;
            if ({state, instret} !== {3'd0, exp_instret}) begin
                failures++;
                $display("FAIL jump%0d_retire: got state=%0d instret=%0d expected 0 %0d",
                         k, state, instret, exp_instret);
            end
        end
    endtask

    // EXEC-stage ALU controls for the remaining ALU instructions.
    task automatic test_alu_ctrl();
        logic [5:0] ops [5] = '{6'b00_1101, 6'b00_1111, 6'b00_1000, 6'b00_0000, 6'b00_0000};
        logic [5:0] fns [5] = '{6'd0, 6'd0, 6'd0, 6'b10_0011, 6'b10_1010};
        logic [2:0] eop [5] = '{3'd2, 3'd4, 3'd0, 3'd1, 3'd3};
        logic       eimm[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       esx [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0] edst[5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        for (int k = 0; k < 5; k++) begin
            opcode = ops[k];
            funct = fns[k];
            next_cyc();
            next_cyc();
            tests_run++;
            if ({state, alu_op, alu_src_imm} !== {3'd2, eop[k], eimm[k]} ||
                (eimm[k] && k != 1 && ext_sign !== esx[k])) begin
                failures++;
                $display("FAIL alu%0d_exec: got state=%0d op=%0d imm=%b sx=%b expected 2 %0d %b %b",
                         k, state, alu_op, alu_src_imm, ext_sign, eop[k], eimm[k], esx[k]);
            end
            next_cyc();
            tests_run++;
            if ({state, reg_write_en, reg_dst, wd_sel, alu_op} !== {3'd4, 1'b1, edst[k], 2'd0, eop[k]}) begin
                failures++;
                $display("FAIL alu%0d_wb: got state=%0d rwe=%b dst=%0d wd=%0d op=%0d expected 4 1 %0d 0 %0d",
                         k, state, reg_write_en, reg_dst, wd_sel, alu_op, edst[k], eop[k]);
            end
            next_cyc();
            exp_instret = exp_instret + 32'd1;
        end
        tests_run++;
        if ({state, instret} !== {3'd0, exp_instret}) begin
            failures++;
            $display("FAIL alu_retire: got state=%0d instret=%0d expected 0 %0d",
                     state, instret, exp_instret);
        end
    endtask

    task automatic test_sw();
        opcode = 6'b10_1011;
        funct = 6'd0;
        next_cyc();
        next_cyc();
        next_cyc();
        tests_run++;
        if ({state, mem_bus.mem_req, mem_bus.mem_we} !== {3'd3, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL sw_mem: got state=%0d req=%b we=%b expected 3 1 1",
                     state, mem_bus.mem_req, mem_bus.mem_we);
        end
        next_cyc();
        exp_instret = exp_instret + 32'd1;
        tests_run++;
        if ({state, instret} !== {3'd0, exp_instret}) begin
            failures++;
            $display("FAIL sw_retire: got state=%0d instret=%0d expected 0 %0d",
                     state, instret, exp_instret);
        end
    endtask

    task automatic test_halt();
        logic [31:0] held;
        held = exp_instret;
        opcode = 6'b11_1111;
        funct = 6'd0;
        next_cyc();
        next_cyc();
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if ({state, halt_sig, illegal, mem_bus.mem_req, pc_write, reg_write_en, instret} !==
                {3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, held}) begin
                failures++;
                $display("FAIL halt_cyc%0d: got state=%0d halt=%b ill=%b req=%b instret=%0d expected 5 1 0 0 %0d",
                         i, state, halt_sig, illegal, mem_bus.mem_req, instret, held);
            end
            next_cyc();
        end
    endtask

    task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
        apply_reset();
        opcode = op;
        funct = fn;
        next_cyc();
        next_cyc();
        next_cyc();
        tests_run++;
        if ({state, halt_sig, illegal, instret} !== {3'd5, 1'b1, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL illegal_%0h_%0h: got state=%0d halt=%b ill=%b instret=%0d expected 5 1 1 0",
                     op, fn, state, halt_sig, illegal, instret);
        end
    endtask

    task automatic test_reset_mid_sw();
        apply_reset();
        opcode = 6'b00_1001;
        next_cyc();
        next_cyc();
        next_cyc();
        next_cyc();
        opcode = 6'b10_1011;
        next_cyc();
        next_cyc();
        next_cyc();
        tests_run++;
        if ({state, instret} !== {3'd3, 32'd1}) begin
            failures++;
            $display("FAIL rst_mid_setup: got state=%0d instret=%0d expected 3 1", state, instret);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({mem_bus.mem_req, mem_bus.mem_we, pc_write, reg_write_en} !== 4'b0) begin
            failures++;
            $display("FAIL rst_mid_strobes: got %b expected 0000",
                     {mem_bus.mem_req, mem_bus.mem_we, pc_write, reg_write_en});
        end
        next_cyc();
        reset = 1'b0;
        #1;
        tests_run++;
        if ({state, instret} !== {3'd0, 32'd0}) begin
            failures++;
            $display("FAIL rst_mid_after: got state=%0d instret=%0d expected 0 0", state, instret);
        end
    endtask

    initial begin
        reset = 1'b1;
        opcode = 6'd0;
        funct = 6'd0;
        zero = 1'b0;
        mem_bus.mem_ready = 1'b1;
        exp_instret = 32'd0;
        test_reset();
        test_addu();
        test_lw_wait();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jumps();
        test_alu_ctrl();
        test_sw();
        test_halt();
        test_illegal(6'b01_0000, 6'd0);
        test_illegal(6'b00_0000, 6'b10_0000);
        test_reset_mid_sw();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
